dds_spi_config: RTL and testbench

SPI-slave configuration controller for the DDS core. It receives 32-bit register-write frames on the external SPI pins, synchronised into the `clk` domain, and holds two frequency tuning words and two phase offsets. It drives the selected tuning word and phase offset to the phase accumulator under control of the `fselect` and `pselect` pins. It sits between the top-level pin wrapper and the DDS phase accumulator / LUT datapath.

---
 rtl/dds_spi_config_if.sv | 26 ++
 rtl/dds_spi_config.sv | 145 ++++++++++++++
 tb/tb_dds_spi_config.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/dds_spi_config_if.sv
// Pin-side bundle of the DDS configuration block: SPI pins and select pins in,
// selected tuning/phase words and status pulses out.
interface dds_spi_config_if #(
  parameter int FREQ_W  = 24,
  parameter int PHASE_W = 12
) ();
  logic               spi_clock;
  logic               spi_cs_n;
  logic               spi_mosi;
  logic               fselect;
  logic               pselect;
  logic [FREQ_W-1:0]  freq_word;
  logic [PHASE_W-1:0] phase_word;
  logic               acc_clear;
  logic               cfg_update;
  logic               frame_err;

  modport master (
    output spi_clock, spi_cs_n, spi_mosi, fselect, pselect,
    input  freq_word, phase_word, acc_clear, cfg_update, frame_err
  );
  modport slave (
    input  spi_clock, spi_cs_n, spi_mosi, fselect, pselect,
    output freq_word, phase_word, acc_clear, cfg_update, frame_err
  );
endinterface

// File: rtl/dds_spi_config.sv
// SPI-slave register file for the DDS core: receives 32-bit write frames,
// holds FREQ0/1 and PHASE0/1, and drives the selected pair to the accumulator.
module dds_spi_config #(
  parameter int FREQ_W      = 24,
  parameter int PHASE_W     = 12,
  parameter int SYNC_STAGES = 2
) (
  input logic             clk,
  input logic             rst,
  dds_spi_config_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  // {cs_n, sclk} need one extra flop for edge detection; levels do not.
  logic [SYNC_STAGES:0][1:0]   edge_sync_q;
  logic [SYNC_STAGES-1:0][2:0] lvl_sync_q;
  logic [SYNC_STAGES:0]        vld_pipe_q;
  logic cs_fall_q, cs_rise_q, sck_rise_q, mosi_q;
  logic cs_cur, cs_prv, sck_cur, sck_prv, fsel, psel, sync_ok;

  state_t             state_q, state_d;
  logic [5:0]         cnt_q;
  logic [31:0]        shreg_q;
  logic [7:0]         addr;
  logic               addr_ok;
  logic [FREQ_W-1:0]  freq0_q, freq1_q, freq0_d, freq1_d, freq_word_q;
  logic [PHASE_W-1:0] phase0_q, phase1_q, phase0_d, phase1_d, phase_word_q;
  logic               acc_clear, cfg_update, frame_err;

  assign cs_cur  = edge_sync_q[SYNC_STAGES-1][1];
  assign cs_prv  = edge_sync_q[SYNC_STAGES][1];
  assign sck_cur = edge_sync_q[SYNC_STAGES-1][0];
  assign sck_prv = edge_sync_q[SYNC_STAGES][0];
  assign fsel    = lvl_sync_q[SYNC_STAGES-1][1];
  assign psel    = lvl_sync_q[SYNC_STAGES-1][2];
  // Edges only count once the chains hold real pin history, so a cs_n held
  // low across reset release is not mistaken for a new frame start.
  assign sync_ok = vld_pipe_q[SYNC_STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_sync_q <= {(SYNC_STAGES+1){2'b10}};
      lvl_sync_q  <= '0;
      vld_pipe_q  <= '0;
      cs_fall_q   <= 1'b0;
      cs_rise_q   <= 1'b0;
      sck_rise_q  <= 1'b0;
      mosi_q      <= 1'b0;
    end else begin
      edge_sync_q <= {edge_sync_q[SYNC_STAGES-1:0], {bus.spi_cs_n, bus.spi_clock}};
      lvl_sync_q  <= {lvl_sync_q[SYNC_STAGES-2:0], {bus.pselect, bus.fselect, bus.spi_mosi}};
      vld_pipe_q  <= {vld_pipe_q[SYNC_STAGES-1:0], 1'b1};
      cs_fall_q   <= sync_ok & ~cs_cur & cs_prv;
      cs_rise_q   <= sync_ok & cs_cur & ~cs_prv;
      sck_rise_q  <= sync_ok & sck_cur & ~sck_prv;
      mosi_q      <= lvl_sync_q[SYNC_STAGES-1][0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cs_fall_q) state_d = SHIFT;
      SHIFT:   if (cs_rise_q) state_d = (cnt_q == 6'd32) ? COMMIT : IDLE;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign addr    = shreg_q[31:24];
  assign addr_ok = (addr <= 8'h04);

  always_comb begin
    cfg_update = 1'b0;
    acc_clear  = 1'b0;
    frame_err  = 1'b0;
    if (state_q == COMMIT) begin
      cfg_update = addr_ok;
      acc_clear  = (addr == 8'h04) && shreg_q[0];
      frame_err  = !addr_ok;
    end else if (state_q == SHIFT && cs_rise_q) begin
      frame_err  = (cnt_q != 6'd0) && (cnt_q != 6'd32);
    end
  end

  // Count saturates at 33 so any overrun length still reads as a bad frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      shreg_q <= '0;
    end else if (state_q == IDLE && cs_fall_q) begin
      cnt_q   <= '0;
      shreg_q <= '0;
    end else if (state_q == SHIFT && sck_rise_q && !cs_rise_q) begin
      shreg_q <= {shreg_q[30:0], mosi_q};
      cnt_q   <= (cnt_q == 6'd33) ? cnt_q : cnt_q + 6'd1;
    end
  end

  always_comb begin
    freq0_d  = freq0_q;
    freq1_d  = freq1_q;
    phase0_d = phase0_q;
    phase1_d = phase1_q;
    if (state_q == COMMIT) begin
      case (addr)
        8'h00:   freq0_d  = shreg_q[FREQ_W-1:0];
        8'h01:   freq1_d  = shreg_q[FREQ_W-1:0];
        8'h02:   phase0_d = shreg_q[PHASE_W-1:0];
        8'h03:   phase1_d = shreg_q[PHASE_W-1:0];
        default: ;
      endcase
    end
  end

  // Outputs mux the next-state contents so a commit shows the following cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      freq0_q      <= '0;
      freq1_q      <= '0;
      phase0_q     <= '0;
      phase1_q     <= '0;
      freq_word_q  <= '0;
      phase_word_q <= '0;
    end else begin
      freq0_q      <= freq0_d;
      freq1_q      <= freq1_d;
      phase0_q     <= phase0_d;
      phase1_q     <= phase1_d;
      freq_word_q  <= fsel ? freq1_d : freq0_d;
      phase_word_q <= psel ? phase1_d : phase0_d;
    end
  end

  assign bus.freq_word  = freq_word_q;
  assign bus.phase_word = phase_word_q;
  assign bus.acc_clear  = acc_clear;
  assign bus.cfg_update = cfg_update;
  assign bus.frame_err  = frame_err;
endmodule

// File: tb/tb_dds_spi_config.sv
// Randomised bench for dds_spi_config: SPI frames in, expected pulses queued
// from a register-map model, a monitor pops them as the DUT emits pulses.
module tb_dds_spi_config;
  localparam int FW = 24;
  localparam int PW = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dds_spi_config_if #(.FREQ_W(FW), .PHASE_W(PW)) bus ();
  dds_spi_config #(.FREQ_W(FW), .PHASE_W(PW), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct packed { logic upd; logic err; logic clr; } ev_t;
  ev_t exp_q[$];
  int checks = 0;
  int errors = 0;
  logic [FW-1:0] freq_m  [2];
  logic [PW-1:0] phase_m [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Register-map model: what a frame of n bits carrying w should do.
  task automatic model_frame(input logic [31:0] w, input int n);
    ev_t e;
    if (n == 0) return;
    e = '0;
    if (n != 32) e.err = 1'b1;
    else begin
      case (w[31:24])
        8'h00: begin freq_m[0]  = w[FW-1:0]; e.upd = 1'b1; end
        8'h01: begin freq_m[1]  = w[FW-1:0]; e.upd = 1'b1; end
        8'h02: begin phase_m[0] = w[PW-1:0]; e.upd = 1'b1; end
        8'h03: begin phase_m[1] = w[PW-1:0]; e.upd = 1'b1; end
        8'h04: begin e.upd = 1'b1; e.clr = w[0]; end
        default: e.err = 1'b1;
      endcase
    end
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    exp_q.delete();
    freq_m[0] = '0; freq_m[1] = '0; phase_m[0] = '0; phase_m[1] = '0;
  endtask

  // clk/8 SPI: 4 clk low with data set up, 4 clk high.
  task automatic shift_bits(input logic [31:0] w, input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      bus.spi_mosi = (i < 32) ? w[31-i] : 1'b0;
      repeat (4) @(negedge clk);
      bus.spi_clock = 1'b1;
      repeat (4) @(negedge clk);
      bus.spi_clock = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [31:0] w, input int n);
    bus.spi_cs_n = 1'b0;
    if (n == 0) repeat (4) @(negedge clk);
    shift_bits(w, 0, n);
    repeat (4) @(negedge clk);
    bus.spi_cs_n = 1'b1;
    model_frame(w, n);
    repeat (4) @(negedge clk);
  endtask

  task automatic readback(input string tag);
    for (int f = 0; f < 2; f++)
      for (int p = 0; p < 2; p++) begin
        bus.fselect = f[0];
        bus.pselect = p[0];
        repeat (5) @(negedge clk);
        chk({tag, "_freq"},  32'(bus.freq_word),  32'(freq_m[f]));
        chk({tag, "_phase"}, 32'(bus.phase_word), 32'(phase_m[p]));
      end
  endtask

  always @(negedge clk) begin
    ev_t got, e;
    if (!rst && (bus.cfg_update || bus.frame_err || bus.acc_clear)) begin
      got = '{bus.cfg_update, bus.frame_err, bus.acc_clear};
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got %b expected none", got);
      end else begin
        e = exp_q.pop_front();
        chk("pulse", 32'(got), 32'(e));
      end
    end
  end

  initial begin
    int lat;
    logic [31:0] r, w;
    bus.spi_clock = 1'b0; bus.spi_cs_n = 1'b1; bus.spi_mosi = 1'b0;
    bus.fselect = 1'b0;   bus.pselect = 1'b0;
    model_reset();

    // Reset with random pin activity
    repeat (8) begin
      r = $urandom();
      bus.spi_clock = r[0]; bus.spi_cs_n = r[1]; bus.spi_mosi = r[2];
      bus.fselect = r[3];   bus.pselect = r[4];
      @(negedge clk);
    end
    chk("rst_freq", 32'(bus.freq_word), 0);
    chk("rst_misc", {bus.phase_word, bus.acc_clear, bus.cfg_update, bus.frame_err}, 0);
    bus.spi_clock = 1'b0; bus.spi_cs_n = 1'b1; bus.fselect = 1'b0; bus.pselect = 1'b0;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("post_rst_freq", 32'(bus.freq_word), 0);
    chk("post_rst_phase", 32'(bus.phase_word), 0);

    // FREQ1 write with latency checks
    bus.fselect = 1'b1;
    repeat (5) @(negedge clk);
    bus.spi_cs_n = 1'b0;
    shift_bits(32'h01123456, 0, 32);
    repeat (4) @(negedge clk);
    bus.spi_cs_n = 1'b1;
    model_frame(32'h01123456, 32);
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (bus.cfg_update) begin lat = k; break; end
    end
    chk("commit_latency", lat, 4);
    @(negedge clk);
    chk("freq1_out", 32'(bus.freq_word), 32'h123456);
    bus.fselect = 1'b0;
    repeat (2) @(negedge clk);
    chk("fsel_hold", 32'(bus.freq_word), 32'h123456);
    @(negedge clk);
    chk("fsel_switch", 32'(bus.freq_word), 0);

    // PHASE0 then CTRL with and without clear
    send_frame(32'h02000ABC, 32);
    send_frame(32'h04000001, 32);
    send_frame(32'h04FFFFFE, 32);
    readback("phase_ctrl");

    // Rejected frames, none may alter registers
    send_frame(32'h00FFFFFF, 31);
    send_frame(32'h03FFFFFF, 33);
    send_frame(32'h07ABCDEF, 32);
    send_frame(32'h00000000, 0);
    readback("bad");

    // Reset in the middle of a frame
    bus.spi_cs_n = 1'b0;
    shift_bits(32'h00FFFFFF, 0, 16);
    rst = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    shift_bits(32'h00FFFFFF, 16, 16);
    repeat (4) @(negedge clk);
    bus.spi_cs_n = 1'b1;
    repeat (8) @(negedge clk);
    readback("midrst");
    send_frame(32'h00ABCDEF, 32);
    readback("after_rst");

    // Back-to-back random frames: all data registers, then random addresses
    for (int i = 0; i < 14; i++) begin
      r = $urandom();
      w = {(i < 4) ? 8'(i) : 8'($urandom_range(0, 7)), r[23:0]};
      send_frame(w, 32);
    end
    readback("tput");

    repeat (20) @(negedge clk);
    chk("pending_pulses", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
